wb_imem_dmem_arbiter: RTL and testbench
=======================================

Name: wb_imem_dmem_arbiter

Overview:
Two-master Wishbone arbiter that merges the core's instruction port (iwb) and data port (dwb) onto one shared memory port (m_*), for a unified single-port RAM. It arbitrates per transfer: one grant covers one transfer and ends on ack, err or watchdog timeout. It routes ack/err only to the granted master and adds a bus watchdog so a silent slave cannot hang the core.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; select width is DATA_WIDTH/8
DATA_PRIORITY, 1, 1 = dwb always wins a tie; 0 = round-robin on ties
TIMEOUT_CYCLES, 255, cycles in grant without ack/err before forced error; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
iwb_adr_i  in  ADDR_WIDTH  fetch address
iwb_cyc_i / iwb_stb_i  in  1 each  fetch cycle / strobe
iwb_dat_o  out  DATA_WIDTH  read data (= m_dat_i)
iwb_ack_o / iwb_err_o  out  1 each  fetch ack / error
dwb_adr_i  in  ADDR_WIDTH  data address
dwb_dat_i  in  DATA_WIDTH  write data
dwb_we_i  in  1  write enable
dwb_sel_i  in  DATA_WIDTH/8  byte selects
dwb_cyc_i / dwb_stb_i  in  1 each  data cycle / strobe
dwb_dat_o  out  DATA_WIDTH  read data (= m_dat_i)
dwb_ack_o / dwb_err_o  out  1 each  data ack / error
m_adr_o, m_dat_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o  out  per master  shared-port request
m_dat_i, m_ack_i, m_err_i  in  per master  shared-port response
grant_o  out  2  00 idle, 01 iwb, 10 dwb
timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (async, immediate):
  - state = IDLE; all m_* outputs, acks, errs, grant_o and timeout_o are 0.
  - last_grant = IWB, so dwb wins the first round-robin tie.
  - Watchdog counter = 0.
- States: IDLE, GNT_I, GNT_D.
- Requests: req_i = iwb_cyc_i & iwb_stb_i; req_d = dwb_cyc_i & dwb_stb_i.
- IDLE transitions:
  - only req_d -> GNT_D; only req_i -> GNT_I.
  - both requesting: DATA_PRIORITY=1 -> GNT_D; DATA_PRIORITY=0 -> the master other than last_grant.
  - Grant registered at that edge: m_stb_o rises exactly 1 cycle after the request is seen.
- In GNT_x:
  - m_adr/dat/sel/we are driven from master x. iwb has m_we_o=0, m_sel_o=all ones, m_dat_o=0.
  - m_cyc_o = x_cyc_i and m_stb_o = x_stb_i (combinational pass-through).
  - x_ack_o = m_ack_i and x_err_o = m_err_i, same cycle, combinational.
  - The other master's ack/err stay 0 and its request is held off.
- Grant release, back to IDLE at the next edge; last_grant := x:
  - m_ack_i or m_err_i seen in GNT_x;
  - x_cyc_i drops (abort; any later ack is ignored);
  - watchdog expiry.
- Re-arbitration: one IDLE cycle always separates two grants. Back-to-back transfers cost 1 extra cycle.
- In IDLE: m_cyc_o = m_stb_o = 0 and all other m_* = 0. A stray m_ack_i/m_err_i is ignored; no master ack/err.
- Watchdog (TIMEOUT_CYCLES>0):
  - counter clears on grant entry and increments each GNT cycle without ack/err.
  - When counter == TIMEOUT_CYCLES-1 and still no ack/err, that cycle: x_err_o=1, timeout_o=1, m_cyc_o=m_stb_o=0; next state IDLE.
  - An ack arriving in the expiry cycle wins: no err, no timeout.
- Read data: iwb_dat_o and dwb_dat_o both mirror m_dat_i unconditionally. Only the ack qualifies them.
- grant_o reflects the registered state.
- Ack and err asserted together by the slave are both forwarded to the master.

Test Plan:
1. Fetch only: iwb_cyc/stb=1, adr=0x100; slave acks 1 cycle after m_stb with 0x00000013 -> m_stb_o high at cycle+1; iwb_ack_o=1 with iwb_dat_o=0x00000013 in the same cycle as m_ack_i; dwb_ack_o stays 0; grant_o goes 01 then 00.
2. Tie, DATA_PRIORITY=1: dwb store adr=0x1000, dat=0x1, sel=0xF and iwb fetch 0x104 raised together -> dwb served first (m_we_o=1, m_adr_o=0x1000); one IDLE cycle; then iwb (m_adr_o=0x104, m_we_o=0). grant_o sequence 10,00,01,00.
3. Tie, DATA_PRIORITY=0, both requesting continuously for 6 transfers -> grants alternate D,I,D,I,D,I.
4. Watchdog, TIMEOUT_CYCLES=4: dwb read, slave never acks -> on the 4th grant cycle dwb_err_o=1 and timeout_o=1, m_cyc_o=0; then IDLE; no iwb_err_o.
5. Slave error: m_err_i=1 during an iwb grant -> iwb_err_o=1 the same cycle; dwb_err_o=0; arbiter returns to IDLE.
6. Reset mid-transfer: assert rst_n=0 during GNT_D before ack -> m_cyc_o, m_stb_o, dwb_ack_o and grant_o go 0 without a clock edge; after release the next tie grants dwb.

Source files
------------

// File: rtl/wb_imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// wb_imem_dmem_arbiter
//
// Merges the core's instruction fetch port (iwb) and data port (dwb) onto a
// single shared Wishbone port (m_*) feeding a unified single-port RAM.
//
// Arbitration happens once per transfer. A grant covers exactly one transfer
// and ends when the slave acks or errs, when the owning master drops cyc, or
// when the bus watchdog expires. One IDLE cycle always separates two grants.
//
// Handshake: a master requests with cyc & stb held high. While it owns the
// bus its cyc/stb pass straight through to m_cyc_o/m_stb_o. The transfer
// completes in the cycle the slave raises m_ack_i (or m_err_i), which is
// forwarded combinationally to the owner only. The master must keep its
// request stable until that cycle.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   iwb_adr_i, iwb_cyc_i,
//   iwb_stb_i                   fetch request (read-only master)
//   iwb_dat_o, iwb_ack_o,
//   iwb_err_o                   fetch response
//   dwb_adr_i, dwb_dat_i,
//   dwb_we_i, dwb_sel_i,
//   dwb_cyc_i, dwb_stb_i        data request
//   dwb_dat_o, dwb_ack_o,
//   dwb_err_o                   data response
//   m_adr_o, m_dat_o, m_sel_o,
//   m_we_o, m_cyc_o, m_stb_o    shared-port request
//   m_dat_i, m_ack_i, m_err_i   shared-port response
//   grant_o                     current owner: 00 idle, 01 iwb, 10 dwb
//   timeout_o                   one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module wb_imem_dmem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DATA_PRIORITY  = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [ADDR_WIDTH-1:0]   iwb_adr_i,
    input  logic                    iwb_cyc_i,
    input  logic                    iwb_stb_i,
    output logic [DATA_WIDTH-1:0]   iwb_dat_o,
    output logic                    iwb_ack_o,
    output logic                    iwb_err_o,

    input  logic [ADDR_WIDTH-1:0]   dwb_adr_i,
    input  logic [DATA_WIDTH-1:0]   dwb_dat_i,
    input  logic                    dwb_we_i,
    input  logic [DATA_WIDTH/8-1:0] dwb_sel_i,
    input  logic                    dwb_cyc_i,
    input  logic                    dwb_stb_i,
    output logic [DATA_WIDTH-1:0]   dwb_dat_o,
    output logic                    dwb_ack_o,
    output logic                    dwb_err_o,

    output logic [ADDR_WIDTH-1:0]   m_adr_o,
    output logic [DATA_WIDTH-1:0]   m_dat_o,
    output logic [DATA_WIDTH/8-1:0] m_sel_o,
    output logic                    m_we_o,
    output logic                    m_cyc_o,
    output logic                    m_stb_o,
    input  logic [DATA_WIDTH-1:0]   m_dat_i,
    input  logic                    m_ack_i,
    input  logic                    m_err_i,

    output logic [1:0]              grant_o,
    output logic                    timeout_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    // The counter only ever has to reach TIMEOUT_CYCLES-1 before the grant
    // is torn down, so clog2(TIMEOUT_CYCLES) bits suffice.
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] WD_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit WD_ENABLED = (TIMEOUT_CYCLES > 0);
    localparam bit DPRIO      = (DATA_PRIORITY != 0);

    // State encoding doubles as the grant_o value.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t               state;
    logic                 last_d;     // 1: dwb held the most recent grant
    logic [CNT_WIDTH-1:0] wd_cnt;

    logic req_i;
    logic req_d;
    logic owner_cyc;
    logic bus_done;
    logic wd_expire;
    logic release_gnt;
    logic pick_d;

    assign req_i = iwb_cyc_i & iwb_stb_i;
    assign req_d = dwb_cyc_i & dwb_stb_i;

    // dwb wins if it is alone, if data has fixed priority, or if iwb was
    // the last owner (round-robin fairness).
    assign pick_d = req_d & (~req_i | DPRIO | ~last_d);

    always_comb begin
        owner_cyc = 1'b0;
        case (state)
            GNT_I:   owner_cyc = iwb_cyc_i;
            GNT_D:   owner_cyc = dwb_cyc_i;
            default: owner_cyc = 1'b0;
        endcase
    end

    assign bus_done = m_ack_i | m_err_i;

    // Expiry only fires when the slave is still silent in the last allowed
    // cycle; a late ack in that same cycle completes the transfer normally.
    assign wd_expire = WD_ENABLED && (state != IDLE) &&
                       (wd_cnt == WD_LAST) && !bus_done;

    assign release_gnt = (state != IDLE) & (bus_done | ~owner_cyc | wd_expire);

    // ------------------------------------------------------------------
    // Arbiter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b0;
            wd_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (pick_d) begin
                        state <= GNT_D;
                    end else if (req_i) begin
                        state <= GNT_I;
                    end
                end
                GNT_I, GNT_D: begin
                    if (release_gnt) begin
                        state  <= IDLE;
                        last_d <= (state == GNT_D);
                    end else if (WD_ENABLED) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign grant_o = state;

    // Read data is not gated: the ack is what qualifies it.
    assign iwb_dat_o = m_dat_i;
    assign dwb_dat_o = m_dat_i;

    // ------------------------------------------------------------------
    // Shared-port mux and response routing
    // ------------------------------------------------------------------
    always_comb begin
        m_adr_o   = '0;
        m_dat_o   = '0;
        m_sel_o   = '0;
        m_we_o    = 1'b0;
        m_cyc_o   = 1'b0;
        m_stb_o   = 1'b0;
        iwb_ack_o = 1'b0;
        iwb_err_o = 1'b0;
        dwb_ack_o = 1'b0;
        dwb_err_o = 1'b0;
        timeout_o = 1'b0;
        case (state)
            GNT_I: begin
                // Fetch port is a read-only, full-word master.
                m_adr_o   = iwb_adr_i;
                m_sel_o   = {SEL_WIDTH{1'b1}};
                m_cyc_o   = iwb_cyc_i & ~wd_expire;
                m_stb_o   = iwb_stb_i & ~wd_expire;
                iwb_ack_o = m_ack_i;
                iwb_err_o = m_err_i | wd_expire;
                timeout_o = wd_expire;
            end
            GNT_D: begin
                m_adr_o   = dwb_adr_i;
                m_dat_o   = dwb_dat_i;
                m_sel_o   = dwb_sel_i;
                m_we_o    = dwb_we_i;
                m_cyc_o   = dwb_cyc_i & ~wd_expire;
                m_stb_o   = dwb_stb_i & ~wd_expire;
                dwb_ack_o = m_ack_i;
                dwb_err_o = m_err_i | wd_expire;
                timeout_o = wd_expire;
            end
            default: begin
                // IDLE: bus quiet, stray slave responses dropped.
            end
        endcase
    end

endmodule

// File: tb/tb_wb_imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for wb_imem_dmem_arbiter.
// Two instances share one randomized stimulus stream:
//   u_dut1: DATA_PRIORITY=1, TIMEOUT_CYCLES=4
//   u_dut0: DATA_PRIORITY=0, TIMEOUT_CYCLES=0 (watchdog disabled)
// Each is checked every cycle against its own transaction-level model, and a
// mid-transfer asynchronous reset is exercised once.
// ---------------------------------------------------------------------------
module tb_wb_imem_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int N_CYCLES = 3000;

  // owner codes used by the reference model
  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;

  typedef struct packed {
    logic [DW-1:0] iwb_dat;
    logic [DW-1:0] dwb_dat;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat;
    logic [SW-1:0] m_sel;
    logic          m_we;
    logic          m_cyc;
    logic          m_stb;
    logic          iwb_ack;
    logic          iwb_err;
    logic          dwb_ack;
    logic          dwb_err;
    logic          tmo;
    logic [1:0]    grant;
  } outs_t;

  typedef struct {
    int owner;   // who holds the bus (OWN_*)
    int age;     // grant cycles already spent without a response
    int last;    // owner of the most recent finished grant
  } mdl_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [AW-1:0] iwb_adr;
  logic          iwb_cyc, iwb_stb;
  logic [AW-1:0] dwb_adr;
  logic [DW-1:0] dwb_dat;
  logic          dwb_we;
  logic [SW-1:0] dwb_sel;
  logic          dwb_cyc, dwb_stb;
  logic [DW-1:0] m_dat_in;
  logic          m_ack, m_err;

  // ---------------- DUT outputs ----------------
  logic [DW-1:0] iwb_dat_1, dwb_dat_1, m_dat_1, iwb_dat_0, dwb_dat_0, m_dat_0;
  logic [AW-1:0] m_adr_1, m_adr_0;
  logic [SW-1:0] m_sel_1, m_sel_0;
  logic          m_we_1, m_cyc_1, m_stb_1, iwb_ack_1, iwb_err_1, dwb_ack_1, dwb_err_1, tmo_1;
  logic          m_we_0, m_cyc_0, m_stb_0, iwb_ack_0, iwb_err_0, dwb_ack_0, dwb_err_0, tmo_0;
  logic [1:0]    grant_1, grant_0;
  outs_t         obs_1, obs_0;

  assign obs_1 = {iwb_dat_1, dwb_dat_1, m_adr_1, m_dat_1, m_sel_1, m_we_1, m_cyc_1, m_stb_1,
                  iwb_ack_1, iwb_err_1, dwb_ack_1, dwb_err_1, tmo_1, grant_1};
  assign obs_0 = {iwb_dat_0, dwb_dat_0, m_adr_0, m_dat_0, m_sel_0, m_we_0, m_cyc_0, m_stb_0,
                  iwb_ack_0, iwb_err_0, dwb_ack_0, dwb_err_0, tmo_0, grant_0};

  wb_imem_dmem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_PRIORITY(1), .TIMEOUT_CYCLES(4)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .iwb_adr_i(iwb_adr), .iwb_cyc_i(iwb_cyc), .iwb_stb_i(iwb_stb),
    .iwb_dat_o(iwb_dat_1), .iwb_ack_o(iwb_ack_1), .iwb_err_o(iwb_err_1),
    .dwb_adr_i(dwb_adr), .dwb_dat_i(dwb_dat), .dwb_we_i(dwb_we), .dwb_sel_i(dwb_sel),
    .dwb_cyc_i(dwb_cyc), .dwb_stb_i(dwb_stb),
    .dwb_dat_o(dwb_dat_1), .dwb_ack_o(dwb_ack_1), .dwb_err_o(dwb_err_1),
    .m_adr_o(m_adr_1), .m_dat_o(m_dat_1), .m_sel_o(m_sel_1), .m_we_o(m_we_1),
    .m_cyc_o(m_cyc_1), .m_stb_o(m_stb_1),
    .m_dat_i(m_dat_in), .m_ack_i(m_ack), .m_err_i(m_err),
    .grant_o(grant_1), .timeout_o(tmo_1)
  );

  wb_imem_dmem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_PRIORITY(0), .TIMEOUT_CYCLES(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .iwb_adr_i(iwb_adr), .iwb_cyc_i(iwb_cyc), .iwb_stb_i(iwb_stb),
    .iwb_dat_o(iwb_dat_0), .iwb_ack_o(iwb_ack_0), .iwb_err_o(iwb_err_0),
    .dwb_adr_i(dwb_adr), .dwb_dat_i(dwb_dat), .dwb_we_i(dwb_we), .dwb_sel_i(dwb_sel),
    .dwb_cyc_i(dwb_cyc), .dwb_stb_i(dwb_stb),
    .dwb_dat_o(dwb_dat_0), .dwb_ack_o(dwb_ack_0), .dwb_err_o(dwb_err_0),
    .m_adr_o(m_adr_0), .m_dat_o(m_dat_0), .m_sel_o(m_sel_0), .m_we_o(m_we_0),
    .m_cyc_o(m_cyc_0), .m_stb_o(m_stb_0),
    .m_dat_i(m_dat_in), .m_ack_i(m_ack), .m_err_i(m_err),
    .grant_o(grant_0), .timeout_o(tmo_0)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic compare_outs(input string who, input outs_t o, input outs_t e);
    check_eq({who, " iwb_dat"}, 64'(o.iwb_dat), 64'(e.iwb_dat));
    check_eq({who, " dwb_dat"}, 64'(o.dwb_dat), 64'(e.dwb_dat));
    check_eq({who, " m_adr"},   64'(o.m_adr),   64'(e.m_adr));
    check_eq({who, " m_dat"},   64'(o.m_dat),   64'(e.m_dat));
    check_eq({who, " m_sel"},   64'(o.m_sel),   64'(e.m_sel));
    check_eq({who, " m_we"},    64'(o.m_we),    64'(e.m_we));
    check_eq({who, " m_cyc"},   64'(o.m_cyc),   64'(e.m_cyc));
    check_eq({who, " m_stb"},   64'(o.m_stb),   64'(e.m_stb));
    check_eq({who, " iwb_ack"}, 64'(o.iwb_ack), 64'(e.iwb_ack));
    check_eq({who, " iwb_err"}, 64'(o.iwb_err), 64'(e.iwb_err));
    check_eq({who, " dwb_ack"}, 64'(o.dwb_ack), 64'(e.dwb_ack));
    check_eq({who, " dwb_err"}, 64'(o.dwb_err), 64'(e.dwb_err));
    check_eq({who, " timeout"}, 64'(o.tmo),     64'(e.tmo));
    check_eq({who, " grant"},   64'(o.grant),   64'(e.grant));
  endtask

  // ---------------- reference model ----------------
  function automatic mdl_t model_reset();
    mdl_t s;
    s.owner = OWN_NONE;
    s.age   = 0;
    s.last  = OWN_I;
    return s;
  endfunction

  function automatic bit model_expired(input mdl_t s, input int to);
    return (s.owner != OWN_NONE) && (to > 0) && (s.age == to - 1) && !m_ack && !m_err;
  endfunction

  // Expected outputs this cycle, given who owns the bus and the live inputs.
  function automatic outs_t predict(input mdl_t s, input int to);
    outs_t e;
    bit    ex;
    e = '0;
    e.iwb_dat = m_dat_in;
    e.dwb_dat = m_dat_in;
    ex = model_expired(s, to);
    if (s.owner == OWN_I) begin
      e.grant   = 2'b01;
      e.m_adr   = iwb_adr;
      e.m_sel   = '1;
      e.m_cyc   = iwb_cyc && !ex;
      e.m_stb   = iwb_stb && !ex;
      e.iwb_ack = m_ack;
      e.iwb_err = m_err || ex;
      e.tmo     = ex;
    end else if (s.owner == OWN_D) begin
      e.grant   = 2'b10;
      e.m_adr   = dwb_adr;
      e.m_dat   = dwb_dat;
      e.m_sel   = dwb_sel;
      e.m_we    = dwb_we;
      e.m_cyc   = dwb_cyc && !ex;
      e.m_stb   = dwb_stb && !ex;
      e.dwb_ack = m_ack;
      e.dwb_err = m_err || ex;
      e.tmo     = ex;
    end
    return e;
  endfunction

  // Ownership after the coming clock edge.
  function automatic mdl_t advance(input mdl_t s, input int dp, input int to);
    mdl_t n;
    bit   wants_i, wants_d, still_cyc, finished;
    n = s;
    wants_i = iwb_cyc && iwb_stb;
    wants_d = dwb_cyc && dwb_stb;
    if (s.owner == OWN_NONE) begin
      n.age = 0;
      if (wants_i && wants_d) n.owner = (dp != 0) ? OWN_D : ((s.last == OWN_D) ? OWN_I : OWN_D);
      else if (wants_d)       n.owner = OWN_D;
      else if (wants_i)       n.owner = OWN_I;
    end else begin
      still_cyc = (s.owner == OWN_I) ? iwb_cyc : dwb_cyc;
      finished  = m_ack || m_err || !still_cyc || model_expired(s, to);
      if (finished) begin
        n.last  = s.owner;
        n.owner = OWN_NONE;
      end else begin
        n.age = s.age + 1;
      end
    end
    return n;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_random();
    iwb_cyc  = iwb_cyc ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
    iwb_stb  = iwb_cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
    dwb_cyc  = dwb_cyc ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
    dwb_stb  = dwb_cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
    iwb_adr  = $urandom;
    dwb_adr  = $urandom;
    dwb_dat  = $urandom;
    dwb_we   = 1'($urandom_range(0, 1));
    dwb_sel  = SW'($urandom_range(0, (1 << SW) - 1));
    m_dat_in = $urandom;
    m_ack    = ($urandom_range(0, 3) == 0);
    m_err    = ($urandom_range(0, 19) == 0);
  endtask

  mdl_t m1, m0;
  bit   rst_done = 1'b0;

  initial begin
    rst_n    = 1'b0;
    iwb_adr  = '0; iwb_cyc = 1'b0; iwb_stb = 1'b0;
    dwb_adr  = '0; dwb_dat = '0; dwb_we = 1'b0; dwb_sel = '0;
    dwb_cyc  = 1'b0; dwb_stb = 1'b0;
    m_dat_in = '0; m_ack = 1'b0; m_err = 1'b0;
    m1 = model_reset();
    m0 = model_reset();

    #3;
    compare_outs("reset d1", obs_1, predict(m1, 4));
    compare_outs("reset d0", obs_0, predict(m0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      drive_random();
      #1;
      compare_outs("d1", obs_1, predict(m1, 4));
      compare_outs("d0", obs_0, predict(m0, 0));
      m1 = advance(m1, 1, 4);
      m0 = advance(m0, 1 - 1, 0);

      // Once, with the data port about to own u_dut1, hit it with reset
      // in the middle of the transfer.
      if (!rst_done && cyc > 500 && m1.owner == OWN_D) begin
        rst_done = 1'b1;
        @(negedge clk);
        dwb_cyc = 1'b1; dwb_stb = 1'b1;
        m_ack = 1'b1; m_err = 1'b0;
        #1;
        check_eq("mid grant d1", 64'(grant_1), 64'(2'b10));
        check_eq("mid dwb_ack d1", 64'(dwb_ack_1), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        check_eq("async rst grant d1", 64'(grant_1), 64'(2'b00));
        check_eq("async rst m_cyc d1", 64'(m_cyc_1), 64'(1'b0));
        check_eq("async rst m_stb d1", 64'(m_stb_1), 64'(1'b0));
        check_eq("async rst dwb_ack d1", 64'(dwb_ack_1), 64'(1'b0));
        check_eq("async rst grant d0", 64'(grant_0), 64'(2'b00));
        m1 = model_reset();
        m0 = model_reset();
        @(negedge clk);
        // Tie right after release: dwb must win on both instances.
        iwb_cyc = 1'b1; iwb_stb = 1'b1;
        dwb_cyc = 1'b1; dwb_stb = 1'b1;
        m_ack = 1'b0; m_err = 1'b0;
        rst_n = 1'b1;
        #1;
        compare_outs("post rst d1", obs_1, predict(m1, 4));
        compare_outs("post rst d0", obs_0, predict(m0, 0));
        m1 = advance(m1, 1, 4);
        m0 = advance(m0, 0, 0);
        @(negedge clk);
        #1;
        check_eq("post rst tie d1", 64'(grant_1), 64'(2'b10));
        check_eq("post rst tie d0", 64'(grant_0), 64'(2'b10));
        compare_outs("post rst g d1", obs_1, predict(m1, 4));
        compare_outs("post rst g d0", obs_0, predict(m0, 0));
        m1 = advance(m1, 1, 4);
        m0 = advance(m0, 0, 0);
      end
      @(negedge clk);
    end

    check_eq("reset event reached", 64'(rst_done), 64'(1'b1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
